// File: rtl/resp_pkg.sv
// Shared constants and helpers for the data SRAM responder: config register
// offsets, the SIMU_FLAG value, and the byte-lane merge used by RAM and registers.
package resp_pkg;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_NUM     = 16'h0008;
    localparam logic [15:0] OFF_TIMER   = 16'h000C;
    localparam logic [15:0] OFF_SIMU    = 16'h0010;
    localparam logic [15:0] OFF_SCRATCH = 16'h0014;

    localparam logic [31:0] SIMU_FLAG_VAL = 32'h0000_0001;

    // Source of the registered read data: config register snapshot or RAM output.
    typedef enum logic {
        SEL_REG = 1'b0,
        SEL_RAM = 1'b1
    } rsel_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/resp_ram.sv
// Single-port byte-writable RAM with synchronous, read-enable-gated read.
// The output register holds its value on cycles without a read.
module resp_ram
    import resp_pkg::*;
#(
    parameter int RAM_AW = 14
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [3:0]        we_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**RAM_AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, we_i);
        if (rd_en_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: internal RAM plus config register window, 1-cycle read latency.
// Optional free-running TIMER register built when DATA_SRAM_RESP_TIMER_EN is defined.
module data_sram_responder
    import resp_pkg::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] CONF_BASE = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    logic        conf_hit;
    logic        rd_req;
    logic        wr_req;
    logic        conf_wr;
    logic [15:0] off_w;
    logic [31:0] reg_rdata;
    logic [31:0] led_merged;
    logic [31:0] timer_rd;
    logic [31:0] ram_rdata;

    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [31:0] scratch_q;
    logic [7:0]  sw_s1_q;
    logic [7:0]  sw_s2_q;
    logic [31:0] rsp_q;
    rsel_e       sel_q;

    assign conf_hit   = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign off_w      = {data_sram_addr[15:2], 2'b00};
    assign rd_req     = data_sram_en && (data_sram_we == 4'h0) && !reset;
    assign wr_req     = data_sram_en && (data_sram_we != 4'h0) && !reset;
    assign conf_wr    = wr_req && conf_hit;
    assign led_merged = byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_we);

    resp_ram #(.RAM_AW(RAM_AW)) u_ram (
        .clk_i   (clk),
        .wr_en_i (wr_req && !conf_hit),
        .rd_en_i (rd_req && !conf_hit),
        .we_i    (data_sram_we),
        .addr_i  (data_sram_addr[RAM_AW+1:2]),
        .wdata_i (data_sram_wdata),
        .rdata_o (ram_rdata)
    );

`ifdef DATA_SRAM_RESP_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] timer_d;

    // A write to TIMER overrides this cycle's increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (conf_wr && off_w == OFF_TIMER)
            timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_we);
    end

    always_ff @(posedge clk) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        reg_rdata = '0;
        case (off_w)
            OFF_LED:     reg_rdata = {16'h0, led_q};
            OFF_SWITCH:  reg_rdata = {24'h0, sw_s2_q};
            OFF_NUM:     reg_rdata = num_q;
            OFF_TIMER:   reg_rdata = timer_rd;
            OFF_SIMU:    reg_rdata = SIMU_FLAG_VAL;
            OFF_SCRATCH: reg_rdata = scratch_q;
            default:     reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            num_q     <= '0;
            scratch_q <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            rsp_q     <= '0;
            sel_q     <= SEL_REG;
        end else begin
            sw_s1_q <= switch;
            sw_s2_q <= sw_s1_q;
            if (conf_wr) begin
                case (off_w)
                    OFF_LED:     led_q     <= led_merged[15:0];
                    OFF_NUM:     num_q     <= byte_merge(num_q, data_sram_wdata, data_sram_we);
                    OFF_SCRATCH: scratch_q <= byte_merge(scratch_q, data_sram_wdata, data_sram_we);
                    default: ;
                endcase
            end
            // Write and idle cycles leave the read path untouched so rdata holds.
            if (rd_req) begin
                sel_q <= conf_hit ? SEL_REG : SEL_RAM;
                if (conf_hit) rsp_q <= reg_rdata;
            end
        end
    end

    assign data_sram_rdata = (sel_q == SEL_RAM) ? ram_rdata : rsp_q;
    assign led             = led_q;
    assign num_data        = num_q;

    logic unused_ok;
    assign unused_ok = ^{data_sram_addr[1:0], led_merged[31:16]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: expected read data is queued
// when a request is driven and compared one edge later.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] CB = 32'hBFAF_0000;

    always #5 clk = ~clk;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch          (switch),
        .led             (led),
        .num_data        (num_data)
    );

    // One clock: inputs applied, then the edge, then outputs sampled #1 later.
    task automatic cyc(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        @(posedge clk);
        #1;
        data_sram_en = 1'b0;
        data_sram_we = 4'h0;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        reset = 1'b1;
        exp_q.push_back(32'h0);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
        reset = 1'b0;
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL reset_rdata got %h want %h", data_sram_rdata, e);
        end
        vec_cnt++;
        if (led !== 16'h0) begin err_cnt++; $display("FAIL reset_led got %h want 0000", led); end
        vec_cnt++;
        if (num_data !== 32'h0) begin err_cnt++; $display("FAIL reset_num got %h want 0", num_data); end
    endtask

    task automatic test_ram_bytewrite;
        logic [31:0] e;
        cyc(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344);
        cyc(1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
        exp_q.push_back(32'h11BB_33DD);
        cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL ram_merge got %h want %h", data_sram_rdata, e);
        end
        // A write cycle must not disturb rdata.
        exp_q.push_back(32'h11BB_33DD);
        cyc(1'b1, 4'hF, 32'h0000_0104, 32'h5555_6666);
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL ram_write_hold got %h want %h", data_sram_rdata, e);
        end
        // Address bits above the RAM index alias back onto the same word.
        exp_q.push_back(32'h11BB_33DD);
        cyc(1'b1, 4'h0, 32'h0001_0100, 32'h0);
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL ram_alias got %h want %h", data_sram_rdata, e);
        end
    endtask

    task automatic test_conf_regs;
        logic [31:0] a [6]  = '{CB + 32'h000, CB + 32'h010, CB + 32'h008,
                                CB + 32'h014, CB + 32'h020, CB + 32'h011};
        logic [31:0] ev [6] = '{32'h0000_1234, 32'h0000_0001, 32'hCA11_BABE,
                                32'h5555_AAAA, 32'h0000_0000, 32'h0000_0001};
        logic [31:0] e;
        cyc(1'b1, 4'hF, CB + 32'h000, 32'hFFFF_1234);
        vec_cnt++;
        if (led !== 16'h1234) begin err_cnt++; $display("FAIL led_out got %h want 1234", led); end
        cyc(1'b1, 4'hF, CB + 32'h008, 32'hCAFE_BABE);
        cyc(1'b1, 4'b0100, CB + 32'h008, 32'h0011_0000);
        vec_cnt++;
        if (num_data !== 32'hCA11_BABE) begin
            err_cnt++; $display("FAIL num_out got %h want ca11babe", num_data);
        end
        cyc(1'b1, 4'hF, CB + 32'h014, 32'h5555_AAAA);
        cyc(1'b1, 4'hF, CB + 32'h010, 32'h1234_5678);
        cyc(1'b1, 4'hF, CB + 32'h020, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ev[i]);
            cyc(1'b1, 4'h0, a[i], 32'h0);
            e = exp_q.pop_front();
            vec_cnt++;
            if (data_sram_rdata !== e) begin
                err_cnt++;
                $display("FAIL conf_read[%0d] addr %h got %h want %h", i, a[i], data_sram_rdata, e);
            end
        end
    endtask

    // Timer loaded at edge E holds FFFF_FFFE after E; reads sampled at E+1, E+2,
    // E+3 see FFFF_FFFE, FFFF_FFFF, then the wrapped 0.
    task automatic test_timer;
        logic [31:0] e;
        cyc(1'b1, 4'hF, CB + 32'h00C, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
`ifdef DATA_SRAM_RESP_TIMER_EN
            exp_q.push_back(32'hFFFF_FFFE + k);
`else
            exp_q.push_back(32'h0);
`endif
            cyc(1'b1, 4'h0, CB + 32'h00C, 32'h0);
            e = exp_q.pop_front();
            vec_cnt++;
            if (data_sram_rdata !== e) begin
                err_cnt++; $display("FAIL timer[%0d] got %h want %h", k, data_sram_rdata, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] dv [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        logic [31:0] e;
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'hF, 32'(i * 4), dv[i]);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(dv[i]);
            cyc(1'b1, 4'h0, 32'(i * 4), 32'h0);
            e = exp_q.pop_front();
            vec_cnt++;
            if (data_sram_rdata !== e) begin
                err_cnt++; $display("FAIL b2b[%0d] got %h want %h", i, data_sram_rdata, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(dv[2]);
            cyc(1'b0, 4'h0, 32'h0000_0000, 32'h0);
            e = exp_q.pop_front();
            vec_cnt++;
            if (data_sram_rdata !== e) begin
                err_cnt++; $display("FAIL idle_hold[%0d] got %h want %h", i, data_sram_rdata, e);
            end
        end
    endtask

    // Switch change sampled at edge E: reads at E and E+1 see the old value, E+2 the new.
    task automatic test_switch;
        logic [31:0] ev [3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_005A};
        logic [31:0] e;
        switch = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(ev[k]);
            cyc(1'b1, 4'h0, CB + 32'h004, 32'h0);
            e = exp_q.pop_front();
            vec_cnt++;
            if (data_sram_rdata !== e) begin
                err_cnt++; $display("FAIL switch[%0d] got %h want %h", k, data_sram_rdata, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e;
        cyc(1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        cyc(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL pre_reset_read got %h want %h", data_sram_rdata, e);
        end
        // Reset cycle carries a write that must be dropped.
        reset = 1'b1;
        exp_q.push_back(32'h0);
        cyc(1'b1, 4'hF, 32'h0000_0200, 32'h0BAD_0BAD);
        reset = 1'b0;
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL midreset_rdata got %h want %h", data_sram_rdata, e);
        end
        vec_cnt++;
        if (led !== 16'h0 || num_data !== 32'h0) begin
            err_cnt++; $display("FAIL midreset_regs got led %h num %h want 0", led, num_data);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        cyc(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL ram_after_reset got %h want %h", data_sram_rdata, e);
        end
        exp_q.push_back(32'h0);
        cyc(1'b1, 4'h0, CB + 32'h014, 32'h0);
        e = exp_q.pop_front();
        vec_cnt++;
        if (data_sram_rdata !== e) begin
            err_cnt++; $display("FAIL scratch_after_reset got %h want %h", data_sram_rdata, e);
        end
    endtask

    initial begin
        reset           = 1'b1;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        switch          = 8'h00;
        #1;
        test_reset();
        test_ram_bytewrite();
        test_conf_regs();
        test_timer();
        test_back_to_back();
        test_switch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
